rnn_param_loader: RTL

//  Upstream feeder for the RNN accelerator: DMA-style loader that walks a parameter table in memory
//  and replays it as register writes (write/addr/data) into the accelerator's load port. Host programs
//  a base address and pulses start; loader fetches header/payload words and pushes them one per write.

---
 rtl/rnn_pkg.sv | 48 ++++
 rtl/rnn_loader_fetch.sv | 67 ++++++
 rtl/rnn_param_loader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rnn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rnn_pkg : shared types and constants for the RNN parameter loader   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package rnn_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_REQ,
        S_HDR_WAIT,
        S_DECODE,
        S_PAY_REQ,
        S_PAY_WAIT,
        S_PUSH,
        S_FINISH,
        S_ACC_GO,
        S_DONE,
        S_ERR
    } loader_state_e;

    localparam logic [31:0] RNN_A_CTRL  = 32'd0;
    localparam logic [31:0] RNN_A_INPUT = 32'd1;
    localparam logic [31:0] RNN_A_REC0  = 32'd2;
    localparam logic [31:0] RNN_A_REC1  = 32'd3;
    localparam logic [31:0] RNN_A_RBIAS = 32'd4;
    localparam logic [31:0] RNN_A_DENSE = 32'd5;
    localparam logic [31:0] RNN_A_DBIAS = 32'd6;

    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_BASE   = 2'd1;
    localparam logic [1:0] CSR_STATUS = 2'd2;
    localparam logic [1:0] CSR_COUNT  = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ERR     = 2;
    localparam int ST_ABORTED = 3;

    function automatic logic target_valid(input logic [2:0] t);
        return (t >= RNN_A_INPUT[2:0]) && (t <= RNN_A_DBIAS[2:0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rnn_loader_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rnn_loader_fetch : single-outstanding read master with address     |
// | counter, wrap detect and captured read word.  Revision: 1.0         |
// +--------------------------------------------------------------------+
module rnn_loader_fetch #(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              req_i,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_read,
    input  logic              m_waitrequest,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid,
    output logic              accept_o,
    output logic              wrap_o,
    output logic [31:0]       word_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] addr_q;
    logic              wrap_q;
    logic              pend_q;
    logic [31:0]       word_q;
    logic [ADDR_W:0]   w_next;

    assign w_next   = {1'b0, addr_q} + (ADDR_W+1)'(WORD_BYTES);
    // A wrapped address is never put on the bus; the owner sees wrap_o instead.
    assign m_read   = req_i && !wrap_q && !pend_q;
    assign accept_o = m_read && !m_waitrequest;
    assign valid_o  = pend_q && m_readdatavalid;
    assign wrap_o   = wrap_q;
    assign m_addr   = addr_q;
    assign word_o   = word_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            wrap_q <= 1'b0;
            pend_q <= 1'b0;
            word_q <= '0;
        end else begin
            if (load_i) begin
                addr_q <= base_i;
                wrap_q <= 1'b0;
            end else if (accept_o) begin
                addr_q <= w_next[ADDR_W-1:0];
                wrap_q <= w_next[ADDR_W];
            end
            if (accept_o) begin
                pend_q <= 1'b1;
            end else if (valid_o) begin
                pend_q <= 1'b0;
            end
            if (valid_o) begin
                word_q <= m_readdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rnn_param_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rnn_param_loader : walks a parameter table in memory and replays it |
// | as accelerator register writes. Option: RNN_LOADER_AUTOSTART_EN     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module rnn_param_loader
    import rnn_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MAX_WORDS  = 1024,
    parameter int WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [1:0]        s_addr,
    input  logic [31:0]       s_wrdata,
    output logic [31:0]       s_rddata,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_read,
    input  logic              m_waitrequest,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid,
    output logic              r_write,
    output logic [31:0]       r_addr,
    output logic [31:0]       r_data,
    output logic              irq
);

    loader_state_e     state_q, state_d;
    logic [15:0]       remain_q;
    logic [2:0]        target_q;
    logic [31:0]       count_q;
    logic [ADDR_W-1:0] base_q;
    logic              aborted_q;
    logic              abort_pend_q;
    logic [31:0]       rddata_q;

    logic        w_busy, w_ctrl_wr, w_launch, w_abort_now, w_abort;
    logic        w_req, w_accept, w_wrap, w_valid, w_push, w_go;
    logic [31:0] w_word, w_status;

    assign w_busy      = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign w_ctrl_wr   = s_write && (s_addr == CSR_CTRL);
    assign w_launch    = w_ctrl_wr && !w_busy && s_wrdata[CTRL_START] && !s_wrdata[CTRL_ABORT];
    assign w_abort_now = w_ctrl_wr && w_busy && s_wrdata[CTRL_ABORT];
    assign w_abort     = w_abort_now || abort_pend_q;
    assign w_req       = (state_q == S_HDR_REQ) || (state_q == S_PAY_REQ);
    assign w_status    = {28'd0, aborted_q, state_q == S_ERR, state_q == S_DONE, w_busy};

    rnn_loader_fetch #(
        .ADDR_W     (ADDR_W),
        .WORD_BYTES (WORD_BYTES)
    ) u_fetch (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_i          (w_launch),
        .base_i          (base_q),
        .req_i           (w_req),
        .m_addr          (m_addr),
        .m_read          (m_read),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .accept_o        (w_accept),
        .wrap_o          (w_wrap),
        .word_o          (w_word),
        .valid_o         (w_valid)
    );

    always_comb begin
        state_d = state_q;
        w_push  = 1'b0;
        w_go    = 1'b0;
        case (state_q)
            S_IDLE: if (w_launch) state_d = S_HDR_REQ;
            S_HDR_REQ, S_PAY_REQ: begin
                // An accepted read must complete before an abort can take effect.
                if (w_wrap)        state_d = S_ERR;
                else if (w_accept) state_d = (state_q == S_HDR_REQ) ? S_HDR_WAIT : S_PAY_WAIT;
                else if (w_abort)  state_d = S_ERR;
            end
            S_HDR_WAIT, S_PAY_WAIT: begin
                if (w_valid) begin
                    if (w_abort)                  state_d = S_ERR;
                    else if (state_q == S_HDR_WAIT) state_d = S_DECODE;
                    else                          state_d = S_PUSH;
                end
            end
            S_DECODE: begin
                if (w_abort)                            state_d = S_ERR;
                else if (w_word[31:16] == 16'd0)        state_d = S_FINISH;
                else if (!target_valid(w_word[2:0]))    state_d = S_ERR;
                else if (count_q >= 32'(MAX_WORDS))     state_d = S_ERR;
                else                                    state_d = S_PAY_REQ;
            end
            S_PUSH: begin
                if (w_abort) begin
                    state_d = S_ERR;
                end else begin
                    w_push = 1'b1;
                    if (remain_q == 16'd1)                    state_d = S_HDR_REQ;
                    else if (count_q + 32'd1 >= 32'(MAX_WORDS)) state_d = S_ERR;
                    else                                      state_d = S_PAY_REQ;
                end
            end
            S_FINISH: begin
                if (w_abort) state_d = S_ERR;
                else begin
`ifdef RNN_LOADER_AUTOSTART_EN
                    state_d = S_ACC_GO;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_ACC_GO: begin
                if (w_abort) state_d = S_ERR;
                else begin
                    w_go    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE, S_ERR: begin
                if (w_launch)       state_d = S_HDR_REQ;
                else if (w_ctrl_wr) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign r_write  = w_push || w_go;
    assign r_addr   = w_push ? {29'd0, target_q} : RNN_A_CTRL;
    assign r_data   = w_push ? w_word : 32'd0;
    assign irq      = (state_q == S_DONE) || (state_q == S_ERR);
    assign s_rddata = rddata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            remain_q     <= '0;
            target_q     <= '0;
            count_q      <= '0;
            base_q       <= '0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            rddata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (s_read) begin
                case (s_addr)
                    CSR_BASE:   rddata_q <= 32'(base_q);
                    CSR_STATUS: rddata_q <= w_status;
                    CSR_COUNT:  rddata_q <= count_q;
                    default:    rddata_q <= 32'd0;
                endcase
            end
            if (s_write && (s_addr == CSR_BASE) && !w_busy) begin
                base_q <= ADDR_W'(s_wrdata);
            end
            if (w_abort_now)                aborted_q <= 1'b1;
            else if (w_ctrl_wr && !w_busy)  aborted_q <= 1'b0;
            abort_pend_q <= (abort_pend_q || w_abort_now) && (state_d != S_ERR);
            if (w_launch)    count_q <= '0;
            else if (w_push) count_q <= count_q + 32'd1;
            if (state_q == S_DECODE) begin
                remain_q <= w_word[31:16];
                target_q <= w_word[2:0];
            end else if (w_push) begin
                remain_q <= remain_q - 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
